sample_jitter_stage: RTL and testbench

- Two-stage pipelined stage wrapped around the raster XOR-tree hash (40-bit in, 8-bit masked out).
- Registers each incoming sample position and drives the hash key and mask from stage-1 registers.
- Consumes the 8-bit hash combinationally in the same cycle and emits a jittered sample position.
- Valid/ready flow control; sits between the sample iterator (upstream) and the sample test (downstream).

---
 rtl/sample_jitter_stage.sv | 97 +++++++++
 tb/tb_sample_jitter_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_jitter_stage.sv
// Two-stage valid/ready pipeline that jitters sample positions with a hash of the sample
// coordinates, offsetting each axis by less than one subsample spacing.
module sample_jitter_stage #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIGFIG-1:0] in_x,
  input  logic [SIGFIG-1:0] in_y,
  input  logic              jitter_en,
  input  logic [1:0]        ss_code,
  output logic [39:0]       hash_key,
  output logic [7:0]        hash_mask,
  input  logic [7:0]        hash_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIGFIG-1:0] out_x,
  output logic [SIGFIG-1:0] out_y,
  output logic [31:0]       sample_count
);

  logic [SIGFIG-1:0] s1_x_q, s1_y_q;
  logic              s1_jit_q;
  logic [1:0]        s1_ss_q;
  logic              s1_valid_q;
  logic [SIGFIG-1:0] s2_x_q, s2_y_q;
  logic              s2_valid_q;
  logic [31:0]       count_q, count_d;

  logic              s1_adv, s2_adv;
  logic [7:0]        hv;
  int unsigned       sh;
  logic [SIGFIG-1:0] off_x, off_y, jit_x, jit_y;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    // Gate locally too so a disabled sample is never offset, whatever the hash returns.
    hv     = s1_jit_q ? hash_val : 8'h00;
    sh     = RADIX - 32'd4 - {30'd0, s1_ss_q};
    off_x  = SIGFIG'(hv[3:0]) << sh;
    off_y  = SIGFIG'(hv[7:4]) << sh;
    jit_x  = s1_x_q + off_x;
    jit_y  = s1_y_q + off_y;
  end

  always_comb begin
    count_d = count_q;
    if (s2_valid_q && out_ready && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_jit_q   <= 1'b0;
      s1_ss_q    <= 2'd0;
      s1_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_x_q   <= in_x;
          s1_y_q   <= in_y;
          s1_jit_q <= jitter_en;
          s1_ss_q  <= ss_code;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_x_q <= jit_x;
          s2_y_q <= jit_y;
        end
      end
      count_q <= count_d;
    end
  end

  assign in_ready     = s1_adv;
  assign hash_key     = {s1_y_q[19:0], s1_x_q[19:0]};
  assign hash_mask    = s1_jit_q ? 8'hFF : 8'h00;
  assign out_valid    = s2_valid_q;
  assign out_x        = s2_x_q;
  assign out_y        = s2_y_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_sample_jitter_stage.sv
// Directed bench for sample_jitter_stage: a hash model drives hash_val and a queue scoreboard
// checks order, values, stall stability, in_ready and the emitted-sample count.
module tb_sample_jitter_stage;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned RADIX  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [SIGFIG-1:0] in_x, in_y;
  logic              jitter_en;
  logic [1:0]        ss_code;
  logic [39:0]       hash_key;
  logic [7:0]        hash_mask;
  logic [7:0]        hash_val;
  logic              out_valid;
  logic              out_ready;
  logic [SIGFIG-1:0] out_x, out_y;
  logic [31:0]       sample_count;

  sample_jitter_stage #(.SIGFIG(SIGFIG), .RADIX(RADIX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .jitter_en    (jitter_en),
    .ss_code      (ss_code),
    .hash_key     (hash_key),
    .hash_mask    (hash_mask),
    .hash_val     (hash_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x        (out_x),
    .out_y        (out_y),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] x;
    logic [23:0] y;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        hmode    = 1'b0;
  logic [7:0]  hconst   = 8'h00;
  logic [31:0] exp_cnt  = 0;
  logic        prev_ov  = 1'b0;
  logic        prev_or  = 1'b0;
  logic [23:0] prev_x, prev_y;

  function automatic logic [7:0] hfun(input logic [39:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24] ^ k[39:32] ^ 8'h5A;
  endfunction

  always_comb hash_val = (hmode ? hfun(hash_key) : hconst) & hash_mask;

  function automatic exp_t model(input logic [23:0] x, input logic [23:0] y, input logic je,
                                 input logic [1:0] ss);
    logic [7:0] h;
    int         s;
    exp_t       e;
    h   = (hmode ? hfun({y[19:0], x[19:0]}) : hconst) & (je ? 8'hFF : 8'h00);
    s   = RADIX - 4 - int'(ss);
    e.x = x + ({20'd0, h[3:0]} << s);
    e.y = y + ({20'd0, h[7:4]} << s);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard work at negedge, then return just after the next posedge.
  task automatic cycle(output bit acc);
    exp_t e;
    @(negedge clk);
    check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    check("sample_count", sample_count, exp_cnt);
    if (prev_ov && !prev_or) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_x", out_x, prev_x);
      check("stall_y", out_y, prev_y);
    end
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("out_x", out_x, e.x);
        check("out_y", out_y, e.y);
        exp_cnt++;
      end
    end
    acc = rst_n && in_valid && in_ready;
    if (acc) q.push_back(model(in_x, in_y, jitter_en, ss_code));
    prev_ov = rst_n && out_valid;
    prev_or = out_ready;
    prev_x  = out_x;
    prev_y  = out_y;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] x, input logic [23:0] y, input logic je,
                      input logic [1:0] ss);
    bit acc;
    int n;
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    jitter_en = je;
    ss_code   = ss;
    acc       = 1'b0;
    n         = 0;
    while (!acc && n < 20) begin
      cycle(acc);
      n++;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  logic [23:0] sx[8];
  logic [23:0] sy[8];

  initial begin
    bit acc;
    int sent;
    int cyc;
    logic [31:0] base;
    logic [3:0]  pat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    jitter_en = 1'b0;
    ss_code   = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count", sample_count, 32'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_x", out_x, 24'd0);

    // Test 1: jitter disabled passes straight through.
    send(24'h000400, 24'h000800, 1'b0, 2'd0);
    check("t1_mask", hash_mask, 8'h00);
    check("t1_lat_early", out_valid, 1'b0);
    cycle(acc);
    check("t1_lat_valid", out_valid, 1'b1);
    check("t1_out_x", out_x, 24'h000400);
    check("t1_out_y", out_y, 24'h000800);
    cycle(acc);
    check("t1_count", sample_count, 32'd1);

    // Test 2: constant hash A5 at ss_code 0.
    hconst = 8'hA5;
    send(24'h000400, 24'h000800, 1'b1, 2'd0);
    check("t2_key", hash_key, {20'h00800, 20'h00400});
    check("t2_mask", hash_mask, 8'hFF);
    cycle(acc);
    check("t2_out_x", out_x, 24'h000540);
    check("t2_out_y", out_y, 24'h000A80);
    cycle(acc);

    // Test 3: ss_code 3 with full hash, x wraps.
    hconst = 8'hFF;
    send(24'hFFFFF0, 24'h000100, 1'b1, 2'd3);
    cycle(acc);
    check("t3_out_x", out_x, 24'h000068);
    check("t3_out_y", out_y, 24'h000178);
    cycle(acc);

    // Test 4: eight back-to-back samples under a 1,0,0,1 out_ready pattern.
    hmode = 1'b1;
    pat   = 4'b1001;
    base  = exp_cnt;
    for (int i = 0; i < 8; i++) begin
      sx[i] = 24'($urandom);
      sy[i] = 24'($urandom);
    end
    sent = 0;
    cyc  = 0;
    while ((sent < 8 || q.size() != 0) && cyc < 100) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_x      = sx[sent];
        in_y      = sy[sent];
        jitter_en = 1'b1;
        ss_code   = 2'(sent % 4);
      end
      cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4_all_sent", sent, 8);
    check("t4_drained", q.size(), 0);
    check("t4_emitted", exp_cnt - base, 32'd8);

    // Test 5: jitter_en captured at accept.
    hmode  = 1'b0;
    hconst = 8'h3C;
    send(24'h001000, 24'h002000, 1'b1, 2'd1);
    jitter_en = 1'b0;
    check("t5_mask_held", hash_mask, 8'hFF);
    cycle(acc);
    check("t5_out_x", out_x, 24'h001180);
    check("t5_out_y", out_y, 24'h002060);
    cycle(acc);

    // Test 6: reset with both stages full drops everything.
    out_ready = 1'b0;
    send(24'h000010, 24'h000020, 1'b1, 2'd2);
    cycle(acc);
    send(24'h000030, 24'h000040, 1'b1, 2'd2);
    check("t6_full", in_ready, 1'b0);
    rst_n = 1'b0;
    cycle(acc);
    rst_n = 1'b1;
    q.delete();
    exp_cnt = 0;
    prev_ov = 1'b0;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_count", sample_count, 32'd0);
    check("t6_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (5) cycle(acc);
    check("t6_no_stale", sample_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
